// File: rtl/teclado_cajero.sv
// teclado_cajero: ATM keypad front end.
// Debounces raw keypad presses, then either forwards PIN digits one at a time
// (MODO=0) or accumulates a decimal amount and delivers it on ENTER (MODO=1).
// Optional build macro TECLADO_TIMEOUT_EN adds an inactivity timer that
// abandons a partially typed amount after TIMEOUT_CYCLES idle cycles.
module teclado_cajero #(
    parameter int DEB_CYCLES     = 4,
    parameter int MAX_DIGITOS    = 9,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        KEY_VALID,
    input  logic [3:0]  KEY_CODE,
    input  logic        MODO,
    output logic [3:0]  DIGITO,
    output logic        DIGITO_STB,
    output logic [31:0] MONTO,
    output logic        MONTO_STB,
    output logic        DESBORDE,
    output logic        CANCELAR
);

    localparam logic [7:0] DEB_LIM    = 8'(DEB_CYCLES);
    localparam logic [3:0] MAX_DIG    = 4'(MAX_DIGITOS);
    localparam logic [3:0] KEY_ENTER  = 4'hA;
    localparam logic [3:0] KEY_CLEAR  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [1:0] {
        RELEASE  = 2'd0,
        IDLE     = 2'd1,
        DEBOUNCE = 2'd2,
        HELD     = 2'd3
    } key_state_t;

    key_state_t  state;
    logic [7:0]  deb_cnt;
    logic [3:0]  code_q;
    logic        evt_pend;
    logic [3:0]  evt_code;

    logic        modo_q;
    logic [31:0] acc;
    logic [3:0]  dcount;

    logic        mode_chg;
    logic [31:0] acc_base;
    logic [3:0]  cnt_base;
    logic [31:0] acc_next_digit;
    logic        timeout_hit;

    // Key FSM: a press must show the same code for DEB_CYCLES consecutive samples
    // before it is accepted, and the key must be released before another press counts.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= RELEASE;
            deb_cnt  <= 8'd0;
            code_q   <= 4'd0;
            evt_pend <= 1'b0;
            evt_code <= 4'd0;
        end else begin
            evt_pend <= 1'b0;
            case (state)
                RELEASE: begin
                    if (!KEY_VALID) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (KEY_VALID) begin
                        code_q  <= KEY_CODE;
                        deb_cnt <= 8'd1;
                        state   <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!KEY_VALID) begin
                        deb_cnt <= 8'd0;
                        state   <= IDLE;
                    end else if (KEY_CODE != code_q) begin
                        code_q  <= KEY_CODE;
                        deb_cnt <= 8'd1;
                    end else if (deb_cnt + 8'd1 == DEB_LIM) begin
                        deb_cnt  <= DEB_LIM;
                        state    <= HELD;
                        evt_pend <= 1'b1;
                        evt_code <= code_q;
                    end else begin
                        deb_cnt <= deb_cnt + 8'd1;
                    end
                end
                HELD: begin
                    if (!KEY_VALID) begin
                        deb_cnt <= 8'd0;
                        state   <= IDLE;
                    end
                end
                default: state <= RELEASE;
            endcase
        end
    end

    // A mode switch wipes the partial amount before any event in the same cycle is applied.
    always_comb begin
        mode_chg       = (MODO != modo_q);
        acc_base       = mode_chg ? 32'd0 : acc;
        cnt_base       = mode_chg ? 4'd0 : dcount;
        acc_next_digit = (acc_base << 3) + (acc_base << 1) + {28'd0, evt_code};
    end

`ifdef TECLADO_TIMEOUT_EN
    logic [31:0] timer;

    assign timeout_hit = !evt_pend && (cnt_base != 4'd0) &&
                         (timer + 32'd1 == 32'(TIMEOUT_CYCLES));

    // Inactivity timer: runs only while an amount is partially typed and restarts on every event.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            timer <= 32'd0;
        end else if (evt_pend || (cnt_base == 4'd0) || timeout_hit) begin
            timer <= 32'd0;
        end else begin
            timer <= timer + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Event decoder: turns each accepted key into a PIN digit, amount update or control pulse.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            modo_q     <= 1'b0;
            acc        <= 32'd0;
            dcount     <= 4'd0;
            DIGITO     <= 4'd0;
            DIGITO_STB <= 1'b0;
            MONTO      <= 32'd0;
            MONTO_STB  <= 1'b0;
            DESBORDE   <= 1'b0;
            CANCELAR   <= 1'b0;
        end else begin
            modo_q     <= MODO;
            DIGITO_STB <= 1'b0;
            MONTO_STB  <= 1'b0;
            DESBORDE   <= 1'b0;
            CANCELAR   <= 1'b0;
            acc        <= acc_base;
            dcount     <= cnt_base;
            if (evt_pend) begin
                if (!MODO) begin
                    if (evt_code <= 4'd9) begin
                        DIGITO     <= evt_code;
                        DIGITO_STB <= 1'b1;
                    end else if (evt_code == KEY_CANCEL) begin
                        acc      <= 32'd0;
                        dcount   <= 4'd0;
                        CANCELAR <= 1'b1;
                    end
                end else begin
                    if (evt_code <= 4'd9) begin
                        if (cnt_base == MAX_DIG) begin
                            DESBORDE <= 1'b1;
                        end else begin
                            acc    <= acc_next_digit;
                            dcount <= cnt_base + 4'd1;
                        end
                    end else begin
                        case (evt_code)
                            KEY_ENTER: begin
                                if (cnt_base != 4'd0) begin
                                    MONTO     <= acc_base;
                                    MONTO_STB <= 1'b1;
                                    acc       <= 32'd0;
                                    dcount    <= 4'd0;
                                end
                            end
                            KEY_CLEAR: begin
                                acc    <= 32'd0;
                                dcount <= 4'd0;
                            end
                            KEY_CANCEL: begin
                                acc      <= 32'd0;
                                dcount   <= 4'd0;
                                CANCELAR <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end else if (timeout_hit) begin
                acc      <= 32'd0;
                dcount   <= 4'd0;
                CANCELAR <= 1'b1;
            end
        end
    end

endmodule
